// File: rtl/count_checker.sv
// Receive-side checker for a free-running +1 counter stream: lock, error pulse, saturating count.
// Optional first-error capture is built when COUNT_CHECKER_FIRST_ERR_EN is defined.
module count_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSE_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic [WIDTH-1:0] err_count,
    output logic [WIDTH-1:0] first_err_got,
    output logic [WIDTH-1:0] first_err_exp
);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] exp_val;
    logic [3:0]       match_run;
    logic [3:0]       miss_run;
    logic [WIDTH-1:0] nxt;
    logic             hit;
    logic             err;

    assign nxt   = din + WIDTH'(1);
    assign hit   = (din == exp_val);
    assign err   = din_valid && (st == LOCKED) && !hit;
    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= HUNT;
            locked    <= 1'b0;
            exp_val   <= '0;
            match_run <= '0;
            miss_run  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err;
            if (clear)
                err_count <= '0;
            else if (err && err_count != {WIDTH{1'b1}})
                err_count <= err_count + WIDTH'(1);

            if (din_valid) begin
                // exp always tracks the last received value, match or not
                exp_val <= nxt;
                unique case (st)
                    HUNT: begin
                        match_run <= 4'd1;
                        st        <= SYNC;
                    end
                    SYNC: begin
                        if (hit) begin
                            match_run <= match_run + 4'd1;
                            if (match_run + 4'd1 == 4'(LOCK_COUNT)) begin
                                st       <= LOCKED;
                                locked   <= 1'b1;
                                miss_run <= '0;
                            end
                        end else begin
                            match_run <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_run <= '0;
                        end else if (miss_run + 4'd1 == 4'(LOSE_COUNT)) begin
                            miss_run <= '0;
                            st       <= HUNT;
                            locked   <= 1'b0;
                        end else begin
                            miss_run <= miss_run + 4'd1;
                        end
                    end
                    default: begin
                        st     <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef COUNT_CHECKER_FIRST_ERR_EN
    logic captured;

    // Capture only the first error; clear re-arms and beats a coincident error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured      <= 1'b0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (clear) begin
            captured      <= 1'b0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (err && !captured) begin
            captured      <= 1'b1;
            first_err_got <= din;
            first_err_exp <= exp_val;
        end
    end
`else
    assign first_err_got = '0;
    assign first_err_exp = '0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Randomised and directed bench for count_checker against a rule-level model.
// Works with or without COUNT_CHECKER_FIRST_ERR_EN.
module tb_count_checker;

    localparam int W    = 8;
    localparam int LOCK = 4;
    localparam int LOSE = 3;
    localparam int MOD  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         clear = 1'b0;
    logic         locked;
    logic [1:0]   state;
    logic         err_pulse;
    logic [W-1:0] err_count;
    logic [W-1:0] first_err_got;
    logic [W-1:0] first_err_exp;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state, kept as plain integers
    int  m_mode;   // 0 hunt, 1 sync, 2 locked
    int  m_exp;
    int  m_good;   // consistent samples in current run, seed included
    int  m_bad;    // consecutive misses while locked
    int  m_errs;
    bit  m_pulse;
    int  m_fg;
    int  m_fe;
    bit  m_have;

    count_checker #(.WIDTH(W), .LOCK_COUNT(LOCK), .LOSE_COUNT(LOSE)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .clear(clear), .locked(locked), .state(state),
        .err_pulse(err_pulse), .err_count(err_count),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0;
        m_errs = 0; m_pulse = 0; m_fg = 0; m_fe = 0; m_have = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        m_pulse = 0;
        if (c) begin
            m_errs = 0; m_fg = 0; m_fe = 0; m_have = 0;
        end
        if (v) begin
            if (m_mode == 0) begin
                m_good = 1;
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_good++;
                    if (m_good == LOCK) begin
                        m_mode = 2;
                        m_bad  = 0;
                    end
                end else begin
                    m_good = 1;
                end
            end else begin
                if (d == m_exp) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1;
                    if (!c) begin
                        if (m_errs < MOD - 1) m_errs++;
                        if (!m_have) begin
                            m_have = 1; m_fg = d; m_fe = m_exp;
                        end
                    end
                    m_bad++;
                    if (m_bad == LOSE) begin
                        m_mode = 0;
                        m_bad  = 0;
                    end
                end
            end
            m_exp = (d + 1) % MOD;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, state, m_mode);
        chk({tag, ".locked"}, locked, (m_mode == 2) ? 1 : 0);
        chk({tag, ".pulse"}, err_pulse, m_pulse);
        chk({tag, ".count"}, err_count, m_errs);
`ifdef COUNT_CHECKER_FIRST_ERR_EN
        chk({tag, ".fgot"}, first_err_got, m_fg);
        chk({tag, ".fexp"}, first_err_exp, m_fe);
`else
        chk({tag, ".fgot"}, first_err_got, 0);
        chk({tag, ".fexp"}, first_err_exp, 0);
`endif
    endtask

    task automatic step(input string tag, input bit v, input int d, input bit c);
        din_valid = v;
        din       = W'(d);
        clear     = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        din_valid = 1'b0;
        clear = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all({tag, ".held"});
    endtask

    task automatic lock_at(input string tag, input int seed);
        for (int i = 0; i < LOCK; i++) step(tag, 1, (seed + i) % MOD, 0);
    endtask

    initial begin
        model_reset();
        do_reset("rst0");

        // lock-up sequence with per-step state expectations
        step("lk0", 1, 'h10, 0); chk("lk0.st", state, 1);
        step("lk1", 1, 'h11, 0); chk("lk1.st", state, 1);
        step("lk2", 1, 'h12, 0); chk("lk2.st", state, 1);
        step("lk3", 1, 'h13, 0); chk("lk3.st", state, 2);
        chk("lk3.locked", locked, 1);

        // wrap-around while locked
        do_reset("rst1");
        lock_at("wrap", 'hF8);
        for (int v = 'hFC; v <= 'h101; v++) step("wrap", 1, v % MOD, 0);
        chk("wrap.locked", locked, 1);
        chk("wrap.count", err_count, 0);

        // single error then resync
        do_reset("rst2");
        lock_at("single", 'h1D);
        step("single", 1, 'h21, 0);
        step("single.err", 1, 'h55, 0);
        chk("single.pulse", err_pulse, 1);
`ifdef COUNT_CHECKER_FIRST_ERR_EN
        chk("single.fg", first_err_got, 'h55);
        chk("single.fe", first_err_exp, 'h22);
`endif
        step("single", 1, 'h56, 0);
        chk("single.cnt", err_count, 1);
        chk("single.st", state, 2);

        // three consecutive misses lose lock
        do_reset("rst3");
        lock_at("lose", 'h30);
        step("lose", 1, 'h00, 0);
        step("lose", 1, 'h80, 0);
        step("lose", 1, 'h40, 0);
        chk("lose.st", state, 0);
        chk("lose.cnt", err_count, 3);
        chk("lose.pulse", err_pulse, 1);

        // gap keeps exp, then clear coinciding with an error
        do_reset("rst4");
        lock_at("gap", 'h60);
        for (int i = 0; i < 5; i++) step("gap", 0, $urandom % MOD, 0);
        step("gap", 1, 'h64, 0);
        chk("gap.locked", locked, 1);
        step("clrerr", 1, 'h99, 0);
        step("clrerr", 1, 'h11, 1);
        chk("clrerr.cnt", err_count, 0);
        chk("clrerr.pulse", err_pulse, 1);

        // saturation: alternate miss / match to stay locked
        do_reset("rst5");
        lock_at("sat", 'h00);
        for (int i = 0; i < 260; i++) begin
            step("sat", 1, (m_exp + 5) % MOD, 0);
            step("sat", 1, m_exp, 0);
        end
        chk("sat.cnt", err_count, 'hFF);
        step("sat", 1, (m_exp + 7) % MOD, 0);
        chk("sat.hold", err_count, 'hFF);
        do_reset("midrst");
        chk("midrst.st", state, 0);
        chk("midrst.cnt", err_count, 0);

        // randomised stream with gaps, jumps and clears
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit c;
            int d;
            v = ($urandom % 8) != 0;
            c = ($urandom % 60) == 0;
            d = (($urandom % 10) == 0) ? int'($urandom % MOD) : m_exp;
            step("rnd", v, d, c);
            if (($urandom % 1000) == 0) do_reset("rndrst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
